// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register-map constants for the MMIO UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uartState_t;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    function automatic logic evenParity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push while full is accepted when a pop happens in the same cycle
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      cnt;
    logic             doPush;
    logic             doPop;

    assign full   = (cnt == DEPTH_CNT);
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign rdData = mem[rdPtr];

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with TX FIFO and STATUS register
// UART_TX_PARITY_EN selects an 8E1 frame; the default build is 8N1.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        Hit,
    output logic [31:0] ReadData,
    output logic        TX
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic        hitData;
    logic        hitStat;
    logic        pushReq;
    logic        clrOvf;
    logic        ovf;
    logic        fifoPop;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [7:0]  fifoData;
    logic [AW:0] fifoCount;
    logic [7:0]  count8;
    logic [31:0] statusWord;
    logic        unusedWriteHi;

    uartState_t  state, stateNext;
    logic [15:0] baudCnt, baudNext;
    logic [2:0]  bitCnt, bitNext;
    logic [7:0]  shiftReg, shiftNext;
    logic        bitEnd;
`ifdef UART_TX_PARITY_EN
    logic        parityBit, parityNext;
`endif

    assign hitData       = (ALUResult == BASE_ADDR + TXDATA_OFS);
    assign hitStat       = (ALUResult == BASE_ADDR + STATUS_OFS);
    assign Hit           = hitData || hitStat;
    assign pushReq       = MemWrite && hitData;
    assign clrOvf        = MemWrite && hitStat && WriteData[STAT_OVF];
    assign unusedWriteHi = ^WriteData[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .clk    (CLK),
        .rst    (Reset),
        .push   (pushReq),
        .pop    (fifoPop),
        .wrData (WriteData[7:0]),
        .rdData (fifoData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ovf <= 1'b0;
        end else if (pushReq && fifoFull && !fifoPop) begin
            ovf <= 1'b1;
        end else if (clrOvf) begin
            ovf <= 1'b0;
        end
    end

    // Count field is 8 bits wide regardless of the FIFO depth.
    generate
        if (AW + 1 >= 8) begin : gCntTrunc
            assign count8 = fifoCount[7:0];
        end else begin : gCntExt
            assign count8 = {{(7 - AW){1'b0}}, fifoCount};
        end
    endgenerate

    always_comb begin
        statusWord                          = '0;
        statusWord[STAT_FULL]               = fifoFull;
        statusWord[STAT_EMPTY]              = fifoEmpty;
        statusWord[STAT_BUSY]               = (state != IDLE);
        statusWord[STAT_OVF]                = ovf;
        statusWord[STAT_CNT_LSB +: 8]       = count8;
    end

    assign ReadData = hitStat ? statusWord : 32'd0;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
`ifdef UART_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            baudCnt   <= baudNext;
            bitCnt    <= bitNext;
            shiftReg  <= shiftNext;
`ifdef UART_TX_PARITY_EN
            parityBit <= parityNext;
`endif
        end
    end

    assign bitEnd = (baudCnt == BIT_LAST);

    always_comb begin
        stateNext  = state;
        baudNext   = baudCnt + 16'd1;
        bitNext    = bitCnt;
        shiftNext  = shiftReg;
        fifoPop    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parityNext = parityBit;
`endif
        case (state)
            IDLE: begin
                baudNext = '0;
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    shiftNext = fifoData;
`ifdef UART_TX_PARITY_EN
                    parityNext = evenParity(fifoData);
`endif
                    stateNext = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    shiftNext = {1'b0, shiftReg[7:1]};
                    bitNext   = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        stateNext = PARITY;
`else
                        stateNext = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    stateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    baudNext  = '0;
                    stateNext = IDLE;
                end
            end
            default: begin
                baudNext  = '0;
                stateNext = IDLE;
            end
        endcase
    end

    // Line is decoded from registered state so reset forces it high immediately.
    always_comb begin
        TX = 1'b1;
        case (state)
            START:   TX = 1'b0;
            DATA:    TX = shiftReg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  TX = parityBit;
`endif
            default: TX = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_mmio_uart_tx;

    localparam int          CPB  = 4;
    localparam int          DEP  = 4;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         startCyc;
        bit         chkGap;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        Hit;
    logic [31:0] ReadData;
    logic        TX;

    exp_t sb[$];
    int   cyc = 0;
    int   checkCnt = 0;
    int   passCnt = 0;
    bit   monBusy = 1'b0;
    bit   ignore = 1'b0;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEP),
        .BASE_ADDR    (BASE)
    ) dut (
        .CLK       (clk),
        .Reset     (Reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .Hit       (Hit),
        .ReadData  (ReadData),
        .TX        (TX)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expectByte(input logic [7:0] d, input int sc, input bit gap);
        exp_t e;
        e.data = d; e.startCyc = sc; e.chkGap = gap;
        sb.push_back(e);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        ALUResult = addr;
        WriteData = data;
        @(posedge clk); #1;
        MemWrite  = 1'b0;
    endtask

    task automatic readAt(input logic [31:0] addr, output logic [31:0] rd, output logic h);
        MemWrite  = 1'b0;
        ALUResult = addr;
        #1;
        rd = ReadData;
        h  = Hit;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || monBusy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < budget), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: decodes frames off the line and compares them against the scoreboard.
    initial begin : monitor
        logic [10:0] bv;
        bit          glitch;
        int          startCyc;
        int          prevEnd;
        exp_t        e;
        prevEnd = -1000;
        forever begin
            @(negedge clk);
            if (Reset || ignore || TX !== 1'b0) continue;
            monBusy  = 1'b1;
            startCyc = cyc;
            glitch   = 1'b0;
            bv       = '1;
            for (int b = 0; b < NB; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (!(b == 0 && c == 0)) @(negedge clk);
                    if (c == 0) bv[b] = TX;
                    else if (TX !== bv[b]) glitch = 1'b1;
                end
            end
            if (sb.size() == 0) begin
                chk("unexpected_frame", {21'd0, bv}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("frame_data", {24'd0, bv[8:1]}, {24'd0, e.data});
                chk("frame_shape", {29'd0, bv[0], bv[NB-1], glitch}, 32'b010);
`ifdef UART_TX_PARITY_EN
                chk("parity_bit", {31'd0, bv[9]}, {31'd0, ^e.data});
`endif
                if (e.startCyc >= 0) chk("start_latency", startCyc, e.startCyc);
                if (e.chkGap) chk("frame_gap", startCyc - prevEnd - 1, 32'd1);
            end
            prevEnd = cyc;
            monBusy = 1'b0;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        h;
        int          n;

        Reset = 1'b1; MemWrite = 1'b0; ALUResult = 32'd0; WriteData = 32'd0;
        #2;
        chk("tx_in_reset", {31'd0, TX}, 32'd1);
        repeat (3) @(posedge clk); #1;
        Reset = 1'b0;

        // Reset state
        repeat (20) @(posedge clk); #1;
        chk("tx_idle", {31'd0, TX}, 32'd1);
        readAt(BASE + 32'd4, rd, h);
        chk("status_reset", rd, 32'h0000_0002);
        chk("hit_status", {31'd0, h}, 32'd1);
        readAt(32'h0000_0100, rd, h);
        chk("hit_other", {31'd0, h}, 32'd0);
        chk("rdata_other", rd, 32'd0);
        readAt(BASE + 32'd8, rd, h);
        chk("hit_base8", {31'd0, h}, 32'd0);
        readAt(BASE, rd, h);
        chk("hit_txdata", {31'd0, h}, 32'd1);
        chk("rdata_txdata", rd, 32'd0);
        @(posedge clk); #1;

        // Single frame with upper data bits ignored
        expectByte(8'h55, cyc + 2, 1'b0);
        store(BASE, 32'hABCD_0055);
        waitDrain(500);
        readAt(BASE + 32'd4, rd, h);
        chk("status_after_frame", rd, 32'h0000_0002);
        @(posedge clk); #1;

        // Three back-to-back stores
        expectByte(8'h41, cyc + 2, 1'b0);
        store(BASE, 32'h41);
        expectByte(8'h42, -1, 1'b1);
        store(BASE, 32'h42);
        expectByte(8'h43, -1, 1'b1);
        store(BASE, 32'h43);
        readAt(BASE + 32'd4, rd, h);
        chk("status_cnt2", rd, 32'h0000_0204);
        waitDrain(1000);

        // Overflow while the serializer is busy
        expectByte(8'h10, cyc + 2, 1'b0);
        store(BASE, 32'h10);
        repeat (4) @(posedge clk); #1;
        for (int i = 1; i <= 6; i++) begin
            if (i <= DEP) expectByte(8'(8'h10 + i), -1, 1'b1);
            store(BASE, 32'(32'h10 + i));
        end
        readAt(BASE + 32'd4, rd, h);
        chk("status_full_ovf", rd, 32'h0000_040D);
        store(BASE + 32'd4, 32'h8);
        readAt(BASE + 32'd4, rd, h);
        chk("status_ovf_clr", rd, 32'h0000_0405);
        waitDrain(2000);
        readAt(BASE + 32'd4, rd, h);
        chk("status_after_ovf", rd, 32'h0000_0002);
        @(posedge clk); #1;

        // Reset in the middle of DATA
        ignore = 1'b1;
        store(BASE, 32'h00);
        repeat (10) @(posedge clk); #3;
        chk("tx_mid_data", {31'd0, TX}, 32'd0);
        Reset = 1'b1;
        #1;
        chk("tx_async_reset", {31'd0, TX}, 32'd1);
        repeat (2) @(posedge clk); #1;
        Reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        readAt(BASE + 32'd4, rd, h);
        chk("status_post_reset", rd, 32'h0000_0002);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (TX !== 1'b1) break;
            n++;
        end
        chk("line_quiet_post_reset", n, 32'd50);
        @(posedge clk); #1;
        ignore = 1'b0;
        expectByte(8'h3C, cyc + 2, 1'b0);
        store(BASE, 32'h3C);
        waitDrain(500);

        // Extreme data patterns, back to back
        expectByte(8'hFF, cyc + 2, 1'b0);
        store(BASE, 32'hFF);
        expectByte(8'h80, -1, 1'b1);
        store(BASE, 32'h80);
        expectByte(8'h07, -1, 1'b1);
        store(BASE, 32'h07);
        waitDrain(1000);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
